burst_ram_arbiter: RTL
======================

Name: burst_ram_arbiter

Overview:
- Shares one BurstRAM command port between two cache controllers: port 0 (instruction cache, read-only) and port 1 (data cache, read/write).
- Sits between the caches and BurstRAM. Each requester sees a BurstRAM-like port; the arbiter serialises whole bursts, latches a losing read request, and routes read beats to the owner only.

Parameters:
- RAM_DEPTH_BITWIDTH, 8, BurstRAM address width.
- RAM_BURST_DATA_BITWIDTH, 64, beat width in bits; divisible by 8.
- RAM_BURST_DATA_COUNT, 4, beats per burst; power of 2, at least 2.

Ports:
- clk  in  1  RAM clock
- rst  in  1  reset, synchronous active-high
- p0_cmd_en  in  1  port 0 read request, single-cycle pulse
- p0_addr  in  RAM_DEPTH_BITWIDTH  port 0 burst address
- p0_rd_data  out  RAM_BURST_DATA_BITWIDTH  read beat; wired to br_rd_data
- p0_rd_data_valid  out  1  beat valid for port 0
- p0_busy  out  1  port 0 must not issue
- p1_cmd  in  1  0=read, 1=write
- p1_cmd_en  in  1  port 1 request pulse
- p1_addr  in  RAM_DEPTH_BITWIDTH  port 1 burst address
- p1_wr_data  in  RAM_BURST_DATA_BITWIDTH  write beat
- p1_data_mask  in  RAM_BURST_DATA_BITWIDTH/8  write byte mask
- p1_rd_data  out  RAM_BURST_DATA_BITWIDTH  wired to br_rd_data
- p1_rd_data_valid  out  1  beat valid for port 1
- p1_busy  out  1  port 1 must not issue
- br_cmd, br_cmd_en  out  1 each  to BurstRAM
- br_addr  out  RAM_DEPTH_BITWIDTH  to BurstRAM
- br_wr_data  out  RAM_BURST_DATA_BITWIDTH  to BurstRAM
- br_data_mask  out  RAM_BURST_DATA_BITWIDTH/8  to BurstRAM
- br_rd_data  in  RAM_BURST_DATA_BITWIDTH  from BurstRAM
- br_rd_data_valid, br_busy  in  1 each  from BurstRAM

Behaviour:
- Reset: state=IDLE, owner=none, both pending flags 0, br_cmd_en=0, br_cmd=0, br_addr=0, br_wr_data=0, br_data_mask=0, last_grant=1, beat counter 0. Reset mid-burst abandons the burst and drops pending requests.
- States: IDLE, READ, WRITE. All br_* outputs are registered.
- pN_busy = pending_N OR (owner==N) OR br_busy. Requesters issue only when their busy is 0.
- pN_rd_data_valid = br_rd_data_valid AND owner==N. This is combinational; the non-owner never sees valid.
- Capture: every cmd_en pulse is latched into pending_N with addr and cmd in the same cycle, in any state.
- Grant (IDLE, br_busy==0, no owner) selects one candidate from the pending flags and same-cycle pulses:
  - A port 1 write always wins. It is never deferred, so write beats are never buffered.
  - Read vs read: round-robin; the port not equal to last_grant wins.
  - The loser stays pending and is granted at the next IDLE with br_busy==0.
- Granted read (cycle T):
  - T+1: br_cmd_en=1, br_cmd=0, br_addr=latched address.
  - br_cmd_en drops after one cycle.
  - In READ, count br_rd_data_valid beats. On beat RAM_BURST_DATA_COUNT: owner=none, state=IDLE, clear that port's pending, last_grant=port.
- Granted write:
  - Only possible as a same-cycle grant of the p1_cmd_en pulse. A write pending behind a burst is not allowed, because port 1 issues only when p1_busy==0.
  - T+1: br_cmd_en=1, br_cmd=1, br_addr, and beat 0 (p1_wr_data/p1_data_mask captured at T).
  - Beats 1..COUNT-1 are taken from p1 on cycles T+1..T+COUNT-1 and presented on br_wr_data one cycle later.
  - After the last beat is presented: owner=none, IDLE, last_grant=1.
- Write requests from port 0 do not exist; that port has no cmd input.
- A new grant requires br_busy==0 in IDLE. Back-to-back bursts are therefore separated by at least one idle cycle.
- p1_cmd_en while p1_busy==1 is a protocol violation. The arbiter ignores it and emits no burst.

Test Plan:
- Single read: p0_cmd_en, addr 0x12 -> br_cmd_en=1 for one cycle with br_addr=0x12, br_cmd=0. 4 br_rd_data_valid beats appear only on p0_rd_data_valid. p0_busy falls the cycle after beat 4.
- Simultaneous reads, p0 addr 0x10, p1 addr 0x20, after reset (last_grant=1) -> p0 is served first, then p1 on 0x20. p1_rd_data_valid stays 0 during p0's beats.
- Simultaneous p0 read 0x05 and p1 write 0x30, beats A0..A3, mask 0xFF -> write first: br_cmd=1, br_addr=0x30, br_wr_data A0..A3 on consecutive cycles. Then the p0 read of 0x05.
- Fairness: p0 and p1 reissue reads continuously for 6 bursts -> grants alternate p0,p1,p0,p1,p0,p1.
- br_busy held high 5 cycles after a p0 request -> no br_cmd_en until br_busy falls; p0_busy=1 throughout.
- rst asserted on beat 2 of a read with p1 pending -> next cycle all outputs are at reset values, pending cleared, p0_busy=p1_busy=0 once br_busy==0.

Source files
------------

// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter: shares one BurstRAM command port between an instruction
// cache (port 0, read-only) and a data cache (port 1, read/write). Whole bursts
// are serialised; a losing read is held pending and read beats reach only the
// port that owns the current burst.
module burst_ram_arbiter #(
  parameter int unsigned RAM_DEPTH_BITWIDTH      = 8,
  parameter int unsigned RAM_BURST_DATA_BITWIDTH = 64,
  parameter int unsigned RAM_BURST_DATA_COUNT    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 p0_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        p0_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   p0_rd_data,
  output logic                                 p0_rd_data_valid,
  output logic                                 p0_busy,
  input  logic                                 p1_cmd,
  input  logic                                 p1_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        p1_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   p1_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] p1_data_mask,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   p1_rd_data,
  output logic                                 p1_rd_data_valid,
  output logic                                 p1_busy,
  output logic                                 br_cmd,
  output logic                                 br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
  output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
  input  logic                                 br_rd_data_valid,
  input  logic                                 br_busy
);

  localparam int unsigned AW = RAM_DEPTH_BITWIDTH;
  localparam int unsigned DW = RAM_BURST_DATA_BITWIDTH;
  localparam int unsigned MW = RAM_BURST_DATA_BITWIDTH / 8;
  localparam int unsigned CW = $clog2(RAM_BURST_DATA_COUNT) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(RAM_BURST_DATA_COUNT - 1);
  localparam logic [CW-1:0] ALL_BEATS = CW'(RAM_BURST_DATA_COUNT);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_t;

  state_t        state_q;
  owner_t        owner_q;
  logic          pend0_q, pend1_q;
  logic          last_grant_q;
  logic [AW-1:0] addr0_q, addr1_q;
  logic [CW-1:0] beat_q;
  logic          br_cmd_q, br_cmd_en_q;
  logic [AW-1:0] br_addr_q;
  logic [DW-1:0] br_wr_data_q;
  logic [MW-1:0] br_data_mask_q;

  logic acc1, wr1, rd1, cand0, cand1, can_grant;
  logic gnt_wr_d, gnt0_d, gnt1_d;
  logic [AW-1:0] rd_addr0, rd_addr1;

  assign p0_busy = pend0_q | (owner_q == OWN_P0) | br_busy;
  assign p1_busy = pend1_q | (owner_q == OWN_P1) | br_busy;

  assign p0_rd_data       = br_rd_data;
  assign p1_rd_data       = br_rd_data;
  assign p0_rd_data_valid = br_rd_data_valid & (owner_q == OWN_P0);
  assign p1_rd_data_valid = br_rd_data_valid & (owner_q == OWN_P1);

  assign br_cmd       = br_cmd_q;
  assign br_cmd_en    = br_cmd_en_q;
  assign br_addr      = br_addr_q;
  assign br_wr_data   = br_wr_data_q;
  assign br_data_mask = br_data_mask_q;

  // Port 1 pulses issued while busy are protocol violations and are dropped.
  // A write that cannot be granted in its own cycle is dropped as well, since
  // its beats cannot be buffered; only reads ever become pending, so no
  // command bit needs to be stored with the pending address.
  assign acc1  = p1_cmd_en & ~p1_busy;
  assign wr1   = acc1 & p1_cmd;
  assign rd1   = acc1 & ~p1_cmd;
  assign cand0 = pend0_q | p0_cmd_en;
  assign cand1 = pend1_q | rd1;
  assign can_grant = (state_q == IDLE) && (owner_q == OWN_NONE) && !br_busy;

  assign rd_addr0 = pend0_q ? addr0_q : p0_addr;
  assign rd_addr1 = pend1_q ? addr1_q : p1_addr;

  // Grant selection: writes win outright, competing reads round-robin.
  always_comb begin
    gnt_wr_d = 1'b0;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    if (can_grant) begin
      if (wr1)                 gnt_wr_d = 1'b1;
      else if (cand0 && cand1) begin
        if (last_grant_q)      gnt0_d = 1'b1;
        else                   gnt1_d = 1'b1;
      end
      else if (cand0)          gnt0_d = 1'b1;
      else if (cand1)          gnt1_d = 1'b1;
    end
  end

  // Request capture, burst FSM and registered BurstRAM command outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= OWN_NONE;
      pend0_q        <= 1'b0;
      pend1_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      addr0_q        <= '0;
      addr1_q        <= '0;
      beat_q         <= '0;
      br_cmd_q       <= 1'b0;
      br_cmd_en_q    <= 1'b0;
      br_addr_q      <= '0;
      br_wr_data_q   <= '0;
      br_data_mask_q <= '0;
    end else begin
      br_cmd_en_q <= 1'b0;
      if (p0_cmd_en) begin
        pend0_q <= 1'b1;
        addr0_q <= p0_addr;
      end
      if (rd1) begin
        pend1_q <= 1'b1;
        addr1_q <= p1_addr;
      end
      unique case (state_q)
        IDLE: begin
          if (gnt_wr_d) begin
            state_q        <= WRITE;
            owner_q        <= OWN_P1;
            br_cmd_en_q    <= 1'b1;
            br_cmd_q       <= 1'b1;
            br_addr_q      <= p1_addr;
            br_wr_data_q   <= p1_wr_data;
            br_data_mask_q <= p1_data_mask;
            beat_q         <= CW'(1);
          end else if (gnt0_d) begin
            state_q     <= READ;
            owner_q     <= OWN_P0;
            br_cmd_en_q <= 1'b1;
            br_cmd_q    <= 1'b0;
            br_addr_q   <= rd_addr0;
            beat_q      <= '0;
          end else if (gnt1_d) begin
            state_q     <= READ;
            owner_q     <= OWN_P1;
            br_cmd_en_q <= 1'b1;
            br_cmd_q    <= 1'b0;
            br_addr_q   <= rd_addr1;
            beat_q      <= '0;
          end
        end
        READ: begin
          if (br_rd_data_valid) begin
            if (beat_q == LAST_BEAT) begin
              state_q <= IDLE;
              owner_q <= OWN_NONE;
              beat_q  <= '0;
              if (owner_q == OWN_P0) begin
                pend0_q      <= 1'b0;
                last_grant_q <= 1'b0;
              end else begin
                pend1_q      <= 1'b0;
                last_grant_q <= 1'b1;
              end
            end else begin
              beat_q <= beat_q + CW'(1);
            end
          end
        end
        WRITE: begin
          // Beat k is sampled from port 1 one cycle after beat k-1; the FSM
          // leaves WRITE only once the final beat has been on br_wr_data.
          if (beat_q != ALL_BEATS) begin
            br_wr_data_q   <= p1_wr_data;
            br_data_mask_q <= p1_data_mask;
            beat_q         <= beat_q + CW'(1);
          end else begin
            state_q      <= IDLE;
            owner_q      <= OWN_NONE;
            beat_q       <= '0;
            last_grant_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          owner_q <= OWN_NONE;
        end
      endcase
    end
  end

endmodule
